// File: rtl/axis_dma_packetizer.sv
// Frames a continuous AXI-Stream into DMA packets of a programmable beat count,
// with a registered output stage and a one-entry skid buffer for backpressure.
module axis_dma_packetizer #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                ps_clk,
    input  logic                rst,
    input  logic                cfg_enable,
    input  logic [LEN_W-1:0]    cfg_pkt_len,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [DATA_W/8-1:0] m_axis_tkeep,
    output logic                m_axis_tlast,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [31:0]         stat_pkt_count,
    output logic                busy
);

    localparam int KEEP_W = DATA_W / 8;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               tready_q, tready_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic               skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0]  skid_data_q, skid_data_d;
    logic               skid_last_q, skid_last_d;
    logic [31:0]        stat_q, stat_d;

    logic               in_hs;
    logic               out_hs;
    logic               in_last;
    logic [LEN_W-1:0]   cfg_len_eff;

    // A programmed length of zero behaves as single-beat packets
    assign cfg_len_eff = (cfg_pkt_len == '0) ? LEN_W'(1) : cfg_pkt_len;
    assign in_hs       = s_axis_tvalid & tready_q;
    assign out_hs      = out_valid_q & m_axis_tready;
    assign in_last     = (cnt_q == (len_q - LEN_W'(1)));

    always_ff @(posedge ps_clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            len_q        <= LEN_W'(1);
            cnt_q        <= '0;
            tready_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
            stat_q       <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            tready_q     <= tready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
            stat_q       <= stat_d;
        end
    end

    // Packet framing: length is captured only when a packet is about to start,
    // and a packet already open always runs to completion even if disabled.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_enable) begin
                    state_d = ST_RUN;
                    len_d   = cfg_len_eff;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (in_hs) begin
                    if (in_last) begin
                        cnt_d = '0;
                        if (cfg_enable) begin
                            len_d = cfg_len_eff;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output register refills from the skid first so ordering is preserved;
    // a beat lands in the skid only when the output is full and stalled.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        if (out_hs) begin
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                out_last_d   = skid_last_q;
                skid_valid_d = 1'b0;
            end else if (in_hs) begin
                out_data_d   = s_axis_tdata;
                out_last_d   = in_last;
            end else begin
                out_valid_d  = 1'b0;
            end
        end else if (in_hs) begin
            if (!out_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = s_axis_tdata;
                out_last_d   = in_last;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = s_axis_tdata;
                skid_last_d  = in_last;
            end
        end
        tready_d = (state_d == ST_RUN) && !skid_valid_d;
        stat_d   = (out_hs && out_last_q) ? stat_q + 32'd1 : stat_q;
    end

    assign s_axis_tready  = tready_q;
    assign m_axis_tvalid  = out_valid_q;
    assign m_axis_tdata   = out_data_q;
    assign m_axis_tlast   = out_last_q;
    assign m_axis_tkeep   = {KEEP_W{out_valid_q}};
    assign stat_pkt_count = stat_q;
    assign busy           = (state_q != ST_IDLE) || out_valid_q || skid_valid_q;

endmodule

// File: doc/axis_dma_packetizer.md
Name: axis_dma_packetizer

Overview:
Sits between the ADC capture FIFO and the AXI DMA S2MM port, replacing the fixed-tlast pass-through. Frames a continuous 32-bit AXI-Stream into DMA packets of a programmable beat count, asserting tlast on the final beat of each packet. Honours full AXI-Stream handshaking in both directions through a registered output stage with a skid buffer, so no word is lost under DMA backpressure. Exposes a completed-packet counter for software.

Parameters:
DATA_W, 32, stream data width in bits; tkeep width is DATA_W/8
LEN_W, 16, width of packet-length configuration and beat counter

Ports:
ps_clk  in  1  stream clock, 100 MHz
rst  in  1  asynchronous active-low reset
cfg_enable  in  1  level; 1 = start and continue framing packets
cfg_pkt_len  in  LEN_W  beats per packet; 0 treated as 1
s_axis_tdata  in  DATA_W  upstream FIFO data
s_axis_tvalid  in  1  upstream valid
s_axis_tready  out  1  ready to upstream
m_axis_tdata  out  DATA_W  data to DMA
m_axis_tkeep  out  DATA_W/8  byte enables, all ones whenever tvalid is 1
m_axis_tlast  out  1  last beat of packet
m_axis_tvalid  out  1  valid to DMA
m_axis_tready  in  1  DMA ready
stat_pkt_count  out  32  packets completed (tlast beats accepted by DMA), wraps
busy  out  1  1 while a packet is open or output/skid registers hold data

Behaviour:
- Reset (rst=0, async assert, sync release): state=IDLE, beat counter=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0, skid empty, stat_pkt_count=0, busy=0. In-flight data is discarded; no partial packet is resumed.
- States:
  - IDLE: s_axis_tready=0. When cfg_enable=1, latch len = max(cfg_pkt_len,1) and go to RUN.
  - RUN: accept beats. On each input handshake, increment the beat counter. The beat where counter==len-1 is tagged last, and the counter clears. After that last beat: if cfg_enable=1, relatch len and stay in RUN; otherwise go to IDLE.
  - Deasserting cfg_enable mid-packet does not truncate the packet. The block keeps accepting beats until the open packet completes, then goes to IDLE.
- cfg_pkt_len is sampled only at packet start. Changes mid-packet take effect on the next packet.
- Datapath: a one-entry output register plus a one-entry skid register, each holding {data,last}.
  - Latency is 1 cycle from input handshake to m_axis_tvalid when the output register is free.
  - s_axis_tready is registered. It is 1 only when state is RUN and the skid register is empty.
  - If the output register is occupied and DMA is not ready when a beat is accepted, the beat goes to the skid register and s_axis_tready drops the next cycle.
  - On an output handshake, the skid contents move to the output register in that same cycle.
  - Order is always preserved.
- m_axis_tvalid, once asserted, stays asserted with stable tdata/tlast until m_axis_tready=1 (AXI rule).
- Input handshake and output handshake in the same cycle: the new beat enters the output register directly; the skid is not used.
- stat_pkt_count increments on each output handshake with tlast=1 and wraps from 0xFFFFFFFF to 0.
- busy = (state!=IDLE) or output valid or skid full.

Test Plan:
- Basic framing: len=4, enable=1, 8 beats 0x0..0x7 with DMA always ready -> outputs 0x0..0x7 one cycle after each input; tlast=1 on 0x3 and 0x7 only; stat_pkt_count=2.
- Backpressure: len=8, continuous input, m_axis_tready low for 5 cycles mid-packet -> s_axis_tready falls within 2 cycles; data held stable; all 8 words appear in order with no duplicates; tlast on the 8th word.
- Zero/one length: cfg_pkt_len=0, 3 beats -> tlast=1 on every beat; stat_pkt_count=3.
- Disable mid-packet: len=4, drop cfg_enable after beat 2 -> beats 3 and 4 still accepted; tlast on beat 4; then s_axis_tready=0 and busy=0 once the output drains.
- Length change mid-packet: len=4, set cfg_pkt_len=2 during beat 1 -> first packet 4 beats, then packets of 2 beats.
- Reset mid-operation: assert rst with the skid full and tvalid high -> all outputs 0 immediately (async); after release with enable=1, the first output word is the next new input with a fresh beat count.
